// File: rtl/bicubic_coord_gen.sv
`default_nettype none
// ============================================================================
// Module   : bicubic_coord_gen
// Purpose  : Per-axis serial divide, then raster-order 7.ACC source coordinates
//            by exact remainder accumulation over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module bicubic_coord_gen #(
  parameter int ACC = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [6:0]     i_h0,
  input  logic [6:0]     i_v0,
  input  logic [4:0]     i_sw,
  input  logic [4:0]     i_sh,
  input  logic [5:0]     i_tw,
  input  logic [5:0]     i_th,
  input  logic           i_coord_ready,
  output logic           o_coord_valid,
  output logic [ACC+6:0] o_coord_x,
  output logic [ACC+6:0] o_coord_y,
  output logic           o_x_frac,
  output logic           o_y_frac,
  output logic [13:0]    o_out_addr,
  output logic           o_last,
  output logic           o_busy,
  output logic           o_done
);

  localparam int NW = ACC + 5;
  localparam int CW = ACC + 7;
  localparam int BW = $clog2(NW);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIVX = 3'd1;
  localparam logic [2:0] S_DIVY = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]    r_state;
  logic [6:0]    r_h0, r_v0;
  logic [4:0]    r_sh;
  logic [5:0]    r_tw, r_th;
  logic [NW-1:0] r_dq;
  logic [5:0]    r_rem;
  logic [BW-1:0] r_bit;
  logic [NW-1:0] r_qx, r_qy;
  logic [5:0]    r_rx, r_ry;
  logic [6:0]    r_acc_x, r_acc_y;
  logic [CW-1:0] r_cx, r_cy;
  logic [5:0]    r_cnt_w, r_cnt_h;
  logic [13:0]   r_addr;
  logic          r_valid;

  logic [5:0]    w_dx, w_dy, w_div;
  logic [6:0]    w_trial, w_rem_next;
  logic          w_qbit;
  logic [NW-1:0] w_q_next;
  logic [6:0]    w_tx, w_ty;
  logic          w_cx_carry, w_cy_carry;
  logic [CW-1:0] w_cx_step, w_cy_step;
  logic [13:0]   w_total;

  assign w_dx = r_tw - 6'd1;
  assign w_dy = r_th - 6'd1;
  assign w_div = (r_state == S_DIVY) ? w_dy : w_dx;

  // Restoring step: remainder stays below the divisor, so 6 bits plus the
  // incoming dividend bit is enough for the trial subtraction.
  assign w_trial    = {r_rem, r_dq[NW-1]};
  assign w_qbit     = (w_trial >= {1'b0, w_div});
  assign w_rem_next = w_qbit ? (w_trial - {1'b0, w_div}) : w_trial;
  assign w_q_next   = {r_dq[NW-2:0], w_qbit};

  assign w_tx       = r_acc_x + {1'b0, r_rx};
  assign w_ty       = r_acc_y + {1'b0, r_ry};
  assign w_cx_carry = (w_tx >= {1'b0, w_dx});
  assign w_cy_carry = (w_ty >= {1'b0, w_dy});
  assign w_cx_step  = {2'b00, r_qx} + CW'(w_cx_carry);
  assign w_cy_step  = {2'b00, r_qy} + CW'(w_cy_carry);

  assign w_total = {8'd0, r_tw} * {8'd0, r_th};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_h0 <= '0; r_v0 <= '0; r_sh <= '0; r_tw <= '0; r_th <= '0;
      r_dq <= '0; r_rem <= '0; r_bit <= '0;
      r_qx <= '0; r_qy <= '0; r_rx <= '0; r_ry <= '0;
      r_acc_x <= '0; r_acc_y <= '0;
      r_cx <= '0; r_cy <= '0;
      r_cnt_w <= '0; r_cnt_h <= '0; r_addr <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_h0 <= i_h0; r_v0 <= i_v0; r_sh <= i_sh;
            r_tw <= i_tw; r_th <= i_th;
            r_dq  <= {i_sw - 5'd1, {ACC{1'b0}}};
            r_rem <= '0;
            r_bit <= '0;
            r_state <= S_DIVX;
          end
        end
        S_DIVX, S_DIVY: begin
          r_dq  <= w_q_next;
          r_rem <= w_rem_next[5:0];
          r_bit <= r_bit + 1'b1;
          if (r_bit == BW'(NW - 1)) begin
            r_bit <= '0;
            r_rem <= '0;
            if (r_state == S_DIVX) begin
              r_qx <= (w_dx == 6'd0) ? '0 : w_q_next;
              r_rx <= (w_dx == 6'd0) ? '0 : w_rem_next[5:0];
              r_dq <= {r_sh - 5'd1, {ACC{1'b0}}};
              r_state <= S_DIVY;
            end else begin
              r_qy <= (w_dy == 6'd0) ? '0 : w_q_next;
              r_ry <= (w_dy == 6'd0) ? '0 : w_rem_next[5:0];
              r_cx <= {r_h0, {ACC{1'b0}}};
              r_cy <= {r_v0, {ACC{1'b0}}};
              r_acc_x <= '0; r_acc_y <= '0;
              r_cnt_w <= '0; r_cnt_h <= '0; r_addr <= '0;
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (r_valid && i_coord_ready) begin
            if (o_last) begin
              r_valid <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_addr <= r_addr + 14'd1;
              if (r_cnt_w != w_dx) begin
                r_cnt_w <= r_cnt_w + 6'd1;
                r_cx    <= r_cx + w_cx_step;
                r_acc_x <= w_cx_carry ? (w_tx - {1'b0, w_dx}) : w_tx;
              end else begin
                r_cnt_w <= '0;
                r_cx    <= {r_h0, {ACC{1'b0}}};
                r_acc_x <= '0;
                r_cnt_h <= r_cnt_h + 6'd1;
                r_cy    <= r_cy + w_cy_step;
                r_acc_y <= w_cy_carry ? (w_ty - {1'b0, w_dy}) : w_ty;
              end
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_coord_valid = r_valid;
  assign o_coord_x     = r_cx;
  assign o_coord_y     = r_cy;
  assign o_x_frac      = |r_cx[ACC-1:0];
  assign o_y_frac      = |r_cy[ACC-1:0];
  assign o_out_addr    = r_addr;
  assign o_last        = r_valid && (r_addr == (w_total - 14'd1));
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_bicubic_coord_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bicubic_coord_gen
// Purpose  : Self-checking bench: directed vector table, random frames against
//            an arithmetic reference model, stall and reset sequences.
// Revision : 1.0
// ============================================================================
module tb_bicubic_coord_gen;
  localparam int ACC = 16;

  logic clk = 1'b0;
  logic rst;
  logic i_start, i_coord_ready;
  logic [6:0] i_h0, i_v0;
  logic [4:0] i_sw, i_sh;
  logic [5:0] i_tw, i_th;
  logic o_coord_valid, o_x_frac, o_y_frac, o_last, o_busy, o_done;
  logic [ACC+6:0] o_coord_x, o_coord_y;
  logic [13:0] o_out_addr;

  always #5 clk = ~clk;

  bicubic_coord_gen #(.ACC(ACC)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_h0(i_h0), .i_v0(i_v0), .i_sw(i_sw), .i_sh(i_sh), .i_tw(i_tw), .i_th(i_th),
    .i_coord_ready(i_coord_ready), .o_coord_valid(o_coord_valid),
    .o_coord_x(o_coord_x), .o_coord_y(o_coord_y),
    .o_x_frac(o_x_frac), .o_y_frac(o_y_frac), .o_out_addr(o_out_addr),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    int h0, v0, sw, sh, tw, th;
    int rmode;
    int stall;
    bit bstart;
  } cfg_t;

  typedef struct {
    int cfg;
    int addr;
    longint x, y;
    bit xf, yf, last;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  logic [ACC+6:0] cap_x [4096];
  logic [ACC+6:0] cap_y [4096];
  bit cap_xf [4096];
  bit cap_yf [4096];
  bit cap_last [4096];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: floor(k*((S-1)<<ACC)/(T-1)) + (origin<<ACC)
  function automatic longint model_coord(input int org, input int s, input int t, input int k);
    longint base;
    base = longint'(org) << ACC;
    if (t == 1) return base;
    return (longint'(k) * (longint'(s - 1) << ACC)) / longint'(t - 1) + base;
  endfunction

  task automatic drive_start(input int h0, v0, sw, sh, tw, th);
    @(negedge clk);
    i_h0 = 7'(h0); i_v0 = 7'(v0); i_sw = 5'(sw); i_sh = 5'(sh);
    i_tw = 6'(tw); i_th = 6'(th);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_h0 = 7'($urandom); i_v0 = 7'($urandom); i_sw = 5'($urandom);
    i_sh = 5'($urandom); i_tw = 6'($urandom); i_th = 6'($urandom);
  endtask

  task automatic run_frame(input int h0, v0, sw, sh, tw, th,
                           input int rmode, input int stall_addr, input bit bstart);
    int cyc, idx, n, guard, stall_cnt;
    bit prev_stall;
    logic [60:0] snap;
    longint ex, ey;
    drive_start(h0, v0, sw, sh, tw, th);
    chk("busy_after_start", o_busy, 1);
    cyc = 1;
    while (!o_coord_valid && cyc < 100) begin
      i_start = bstart && (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    chk("latency", cyc, 43);
    n = tw * th; idx = 0; guard = 0; stall_cnt = 0; prev_stall = 0; snap = '0;
    while (idx < n && guard < 20000) begin
      if (!o_coord_valid) begin
        chk("valid_drop", 0, 1);
        break;
      end
      if (prev_stall)
        chk("stall_hold", {o_coord_x, o_coord_y, o_out_addr, o_last}, snap);
      if (idx == stall_addr && stall_cnt < 5) begin
        i_coord_ready = 1'b0;
        stall_cnt++;
      end else if (rmode != 0) i_coord_ready = ($urandom_range(0, 2) != 0);
      else i_coord_ready = 1'b1;
      if (i_coord_ready) begin
        ex = model_coord(h0, sw, tw, idx % tw);
        ey = model_coord(v0, sh, th, idx / tw);
        chk("addr", o_out_addr, idx);
        chk("coord_x", o_coord_x, ex);
        chk("coord_y", o_coord_y, ey);
        chk("x_frac", o_x_frac, (ex % 65536) != 0);
        chk("y_frac", o_y_frac, (ey % 65536) != 0);
        chk("last", o_last, idx == n - 1);
        cap_x[idx] = o_coord_x; cap_y[idx] = o_coord_y;
        cap_xf[idx] = o_x_frac; cap_yf[idx] = o_y_frac; cap_last[idx] = o_last;
        idx++;
      end
      snap = {o_coord_x, o_coord_y, o_out_addr, o_last};
      prev_stall = !i_coord_ready;
      @(negedge clk);
      guard++;
    end
    chk("all_emitted", idx, n);
    chk("done_pulse", o_done, 1);
    chk("valid_after_last", o_coord_valid, 0);
    i_coord_ready = 1'b0;
    @(negedge clk);
    chk("done_clear", o_done, 0);
    chk("busy_clear", o_busy, 0);
  endtask

  cfg_t dirs[5];
  vec_t vecs[$];

  initial begin
    int cnt, sw, sh;
    rst = 1'b1; i_start = 1'b0; i_coord_ready = 1'b0;
    i_h0 = '0; i_v0 = '0; i_sw = '0; i_sh = '0; i_tw = '0; i_th = '0;

    dirs[0] = '{0, 0, 4, 4, 4, 4, 0, -1, 0};
    dirs[1] = '{10, 0, 4, 1, 7, 1, 0, -1, 0};
    dirs[2] = '{0, 0, 5, 1, 7, 1, 0, -1, 1};
    dirs[3] = '{5, 7, 1, 1, 1, 1, 0, -1, 0};
    dirs[4] = '{0, 0, 4, 4, 4, 4, 0, 3, 0};

    vecs.push_back('{0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 5, 'h10000, 'h10000, 0, 0, 0});
    vecs.push_back('{0, 7, 'h30000, 'h10000, 0, 0, 0});
    vecs.push_back('{0, 15, 'h30000, 'h30000, 0, 0, 1});
    vecs.push_back('{1, 1, 'hA8000, 0, 1, 0, 0});
    vecs.push_back('{1, 3, 'hB8000, 0, 1, 0, 0});
    vecs.push_back('{1, 4, 'hC0000, 0, 0, 0, 0});
    vecs.push_back('{1, 6, 'hD0000, 0, 0, 0, 1});
    vecs.push_back('{2, 1, 43690, 0, 1, 0, 0});
    vecs.push_back('{2, 2, 87381, 0, 1, 0, 0});
    vecs.push_back('{2, 3, 131072, 0, 0, 0, 0});
    vecs.push_back('{2, 4, 174762, 0, 1, 0, 0});
    vecs.push_back('{2, 5, 218453, 0, 1, 0, 0});
    vecs.push_back('{2, 6, 262144, 0, 0, 0, 1});
    vecs.push_back('{3, 0, 'h50000, 'h70000, 0, 0, 1});
    vecs.push_back('{4, 3, 'h30000, 0, 0, 0, 0});
    vecs.push_back('{4, 4, 0, 'h10000, 0, 0, 0});

    repeat (3) @(negedge clk);
    chk("rst_valid", o_coord_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_last", o_last, 0);
    chk("rst_xy", {o_coord_x, o_coord_y}, 0);
    chk("rst_addr", o_out_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(dirs[i].h0, dirs[i].v0, dirs[i].sw, dirs[i].sh, dirs[i].tw, dirs[i].th,
                dirs[i].rmode, dirs[i].stall, dirs[i].bstart);
      foreach (vecs[j]) begin
        if (vecs[j].cfg == i) begin
          chk("vec_x", cap_x[vecs[j].addr], vecs[j].x);
          chk("vec_y", cap_y[vecs[j].addr], vecs[j].y);
          chk("vec_xf", cap_xf[vecs[j].addr], vecs[j].xf);
          chk("vec_yf", cap_yf[vecs[j].addr], vecs[j].yf);
          chk("vec_last", cap_last[vecs[j].addr], vecs[j].last);
        end
      end
    end

    // Reset while emitting at OUT_ADDR=6, then replay from scratch.
    drive_start(0, 0, 4, 4, 4, 4);
    i_coord_ready = 1'b1;
    cnt = 0;
    while (!(o_coord_valid && o_out_addr == 14'd6) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_addr6", o_out_addr, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", o_coord_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_outs", {o_coord_x, o_coord_y, o_out_addr, o_last, o_done}, 0);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (o_coord_valid || o_busy) cnt++;
    end
    chk("idle_after_rst", cnt, 0);
    i_coord_ready = 1'b0;
    run_frame(0, 0, 4, 4, 4, 4, 0, -1, 0);

    for (int r = 0; r < 14; r++) begin
      int h0, v0, tw, th;
      sw = $urandom_range(1, 31);
      sh = $urandom_range(1, 31);
      h0 = $urandom_range(0, 100 - sw);
      v0 = $urandom_range(0, 100 - sh);
      tw = $urandom_range(1, 63);
      th = $urandom_range(1, 12);
      run_frame(h0, v0, sw, sh, tw, th, 1, $urandom_range(0, 20), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
